class_search_seq: RTL and testbench
===================================

Name: class_search_seq

Overview:
Sequential associative-memory reader that sits after the class-accumulation block (mux_and_top) in the sparse HDC pipeline. It takes one 50-bit query hypervector and scans the 26 binarized class hypervectors (a..z) one per cycle. Each scan step scores the query against one class with the sparse similarity popcount(query AND class). It reports the best-scoring class index and its score with a one-cycle valid pulse.

Parameters:
HV_WIDTH, 50, hypervector dimension in bits
NUM_CLASSES, 26, number of class hypervectors (a..z)
CLASS_W, 5, class index width
SCORE_W, 6, similarity score width (holds 0..HV_WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
query_ready  input  1  query present on query_hv
query_hv  input  HV_WIDTH  query hypervector
class_hv_flat  input  NUM_CLASSES*HV_WIDTH  class HVs concatenated; class k at bits [k*HV_WIDTH +: HV_WIDTH] (a=0 .. z=25)
accept_en  output  1  high when the block can accept a query
busy  output  1  high in SCAN or DONE
state  output  2  current FSM state (IDLE=0, SCAN=1, DONE=2)
result_valid  output  1  one-cycle pulse: result fields are new
result_class  output  CLASS_W  index of best class
result_score  output  SCORE_W  popcount(query AND best class)

Behaviour:
- Reset (asynchronous, any time): state=IDLE, accept_en=1, busy=0, result_valid=0, result_class=0, result_score=0, internal query, idx and best registers all 0.
- accept_en = (state==IDLE), combinational from the state register.
- IDLE transition:
  - On an edge with query_ready=1 and accept_en=1 (edge E0): latch query_hv, set idx=0, best_score=0, best_class=0, go to SCAN.
  - With query_ready=0: stay in IDLE.
- SCAN: at each edge Ek (k=1..26), for idx=k-1:
  - score = popcount(query_lat AND class_hv[idx]), computed in SCORE_W bits with no overflow possible.
  - If score > best_score (strict), update best_score and best_class; ties keep the lower index.
  - idx increments.
  - At the edge that processes idx=NUM_CLASSES-1, load result_class and result_score from the final best values (including that last comparison) and go to DONE.
- DONE: result_valid=1 for exactly this one cycle. The next edge returns to IDLE.
- Latency: accept at E0; result_valid is high during the cycle after E26. The earliest next accept is E28, giving a throughput of one query per 28 cycles.
- query_ready or query_hv changes while busy: ignored. Nothing is queued; the latched query is used.
- class_hv_flat is sampled live each SCAN cycle. Upstream holds it stable during a scan; no snapshot is taken.
- result_class and result_score hold their last values until the next DONE load. They are not cleared on accept.
- All-zero scores: result_class=0, result_score=0, valid still pulses.
- Reset during SCAN or DONE: abort with no result_valid pulse. Outputs return to reset values.
- idx never exceeds NUM_CLASSES-1; no wrap-around state is reachable.

Decomposition:
- Shared package hdc_pkg:
  - HV_WIDTH, NUM_CLASSES, CLASS_W, SCORE_W.
  - State encodings IDLE/SCAN/DONE.
  - Same constants used by mux_and_top.
- One sub-module: and_popcount, combinational. Inputs are two HV_WIDTH vectors; output is a SCORE_W count of bitwise-AND ones. It is reusable by later similarity blocks.
- Class selection mux (idx -> HV_WIDTH slice) stays inside class_search_seq.

Test Plan:
- Class 3 (d) = 50'd255, all others 0; rst pulse, then query_hv=50'd255, query_ready=1 -> result_valid only in the cycle after E26, result_class=3, result_score=8; accept_en low for cycles E0..E27.
- Classes 2 and 5 = 50'hF0, all others 0; query 50'hFF -> result_class=2, result_score=4 (tie goes to lower index).
- All class HVs 0; query 50'h3_FFFF_FFFF_FFFF -> result_class=0, result_score=0, valid still pulses once.
- Class 25 (z) = all ones, class 0 = 50'h1; query all ones -> result_class=25, result_score=50, confirming no score overflow.
- query_ready held high for 100 cycles with a fixed query -> exactly 3 result_valid pulses, spaced 28 cycles apart; query_hv changed mid-scan does not alter the result.
- Assert rst for one cycle at cycle 10 of a scan -> no result_valid; state=0, accept_en=1, result_class=0 and result_score=0 immediately. A new query afterwards completes normally.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared constants and FSM encoding for the sparse HDC pipeline.
// Used by the class search block, mux_and_top and similarity helpers.
package hdc_pkg;

    localparam int HV_WIDTH    = 50;
    localparam int NUM_CLASSES = 26;
    localparam int CLASS_W     = 5;
    localparam int SCORE_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/and_popcount.sv
// Sparse similarity: number of bit positions set in both vectors.
// Purely combinational so later similarity blocks can reuse it.
module and_popcount
    import hdc_pkg::*;
(
    input  logic [HV_WIDTH-1:0] a,
    input  logic [HV_WIDTH-1:0] b,
    output logic [SCORE_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < HV_WIDTH; i++) begin
            count = count + SCORE_W'(a[i] & b[i]);
        end
    end

endmodule

// File: rtl/class_search_seq.sv
// Sequential associative-memory reader: scans one class HV per cycle
// and reports the best popcount(query AND class) with a valid pulse.
module class_search_seq
    import hdc_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            query_ready,
    input  logic [HV_WIDTH-1:0]             query_hv,
    input  logic [NUM_CLASSES*HV_WIDTH-1:0] class_hv_flat,
    output logic                            accept_en,
    output logic                            busy,
    output logic [1:0]                      state,
    output logic                            result_valid,
    output logic [CLASS_W-1:0]              result_class,
    output logic [SCORE_W-1:0]              result_score
);

    state_t              state_q;
    state_t              state_d;
    logic [HV_WIDTH-1:0] query_q;
    logic [CLASS_W-1:0]  idx_q;
    logic [SCORE_W-1:0]  best_score_q;
    logic [CLASS_W-1:0]  best_class_q;
    logic [HV_WIDTH-1:0] cur_class;
    logic [SCORE_W-1:0]  score;
    logic                better;
    logic                last;

    // Class slice selected by the scan index; read live every cycle.
    always_comb begin
        cur_class = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (idx_q == CLASS_W'(k)) begin
                cur_class = class_hv_flat[k*HV_WIDTH +: HV_WIDTH];
            end
        end
    end

    and_popcount u_pop (
        .a     (query_q),
        .b     (cur_class),
        .count (score)
    );

    // Strict compare so ties keep the lower class index.
    assign better = score > best_score_q;
    assign last   = idx_q == CLASS_W'(NUM_CLASSES - 1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (query_ready) state_d = SCAN;
            SCAN:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            query_q      <= '0;
            idx_q        <= '0;
            best_score_q <= '0;
            best_class_q <= '0;
            result_class <= '0;
            result_score <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (query_ready) begin
                        query_q      <= query_hv;
                        idx_q        <= '0;
                        best_score_q <= '0;
                        best_class_q <= '0;
                    end
                end
                SCAN: begin
                    if (better) begin
                        best_score_q <= score;
                        best_class_q <= idx_q;
                    end
                    if (last) begin
                        result_class <= better ? idx_q : best_class_q;
                        result_score <= better ? score : best_score_q;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign accept_en    = state_q == IDLE;
    assign busy         = (state_q == SCAN) || (state_q == DONE);
    assign result_valid = state_q == DONE;
    assign state        = state_q;

endmodule

// File: tb/tb_class_search_seq.sv
// Self-checking bench for class_search_seq against a reference
// model that picks the first class with the highest AND-popcount.
module tb_class_search_seq;
    import hdc_pkg::*;

    logic                            clk;
    logic                            rst;
    logic                            query_ready;
    logic [HV_WIDTH-1:0]             query_hv;
    logic [NUM_CLASSES*HV_WIDTH-1:0] class_hv_flat;
    logic                            accept_en;
    logic                            busy;
    logic [1:0]                      state;
    logic                            result_valid;
    logic [CLASS_W-1:0]              result_class;
    logic [SCORE_W-1:0]              result_score;

    logic [HV_WIDTH-1:0] cls [NUM_CLASSES];
    int n_cmp;
    int n_fail;

    localparam logic [HV_WIDTH-1:0] ONES = {HV_WIDTH{1'b1}};

    class_search_seq dut (
        .clk           (clk),
        .rst           (rst),
        .query_ready   (query_ready),
        .query_hv      (query_hv),
        .class_hv_flat (class_hv_flat),
        .accept_en     (accept_en),
        .busy          (busy),
        .state         (state),
        .result_valid  (result_valid),
        .result_class  (result_class),
        .result_score  (result_score)
    );

    always_comb begin
        class_hv_flat = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            class_hv_flat[k*HV_WIDTH +: HV_WIDTH] = cls[k];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // First class with the maximum overlap wins; empty overlap gives 0/0.
    task automatic model(input logic [HV_WIDTH-1:0] q,
                         output int m_cls, output int m_score);
        m_cls = 0;
        m_score = 0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if ($countones(q & cls[k]) > m_score) begin
                m_score = $countones(q & cls[k]);
                m_cls = k;
            end
        end
    endtask

    task automatic clear_classes();
        for (int k = 0; k < NUM_CLASSES; k++) cls[k] = '0;
    endtask

    function automatic logic [HV_WIDTH-1:0] rand_hv();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[HV_WIDTH-1:0];
    endfunction

    // Issues one query and observes 28 cycles after the accept edge.
    task automatic run_query(input logic [HV_WIDTH-1:0] q,
                             output int v_cnt, output int v_at,
                             output int r_cls, output int r_score,
                             output int acc_bad);
        v_cnt = 0;
        v_at = -1;
        r_cls = -1;
        r_score = -1;
        acc_bad = 0;
        @(negedge clk);
        query_hv = q;
        query_ready = 1'b1;
        @(posedge clk);
        #1 query_ready = 1'b0;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            if (accept_en !== (c == 27)) acc_bad++;
            if (result_valid === 1'b1) begin
                v_cnt++;
                if (v_at < 0) begin
                    v_at = c;
                    r_cls = int'(result_class);
                    r_score = int'(result_score);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        query_ready = 1'b0;
        query_hv = '0;
        clear_classes();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (state !== 2'd0 || accept_en !== 1'b1 || busy !== 1'b0 ||
            result_valid !== 1'b0 || result_class !== '0 ||
            result_score !== '0) begin
            n_fail++;
            $display("FAIL reset: st=%0d acc=%b busy=%b v=%b cls=%0d sc=%0d want 0/1/0/0/0/0",
                     state, accept_en, busy, result_valid, result_class, result_score);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_query(input string name, input logic [HV_WIDTH-1:0] q);
        int v_cnt, v_at, r_cls, r_score, acc_bad, m_cls, m_score;
        model(q, m_cls, m_score);
        run_query(q, v_cnt, v_at, r_cls, r_score, acc_bad);
        n_cmp++;
        if (v_cnt !== 1 || v_at !== 26) begin
            n_fail++;
            $display("FAIL %s valid: pulses=%0d at=%0d want 1 at 26", name, v_cnt, v_at);
        end
        n_cmp++;
        if (r_cls !== m_cls || r_score !== m_score) begin
            n_fail++;
            $display("FAIL %s result: cls=%0d score=%0d want cls=%0d score=%0d",
                     name, r_cls, r_score, m_cls, m_score);
        end
        n_cmp++;
        if (acc_bad !== 0) begin
            n_fail++;
            $display("FAIL %s accept_en: %0d bad cycles want 0", name, acc_bad);
        end
    endtask

    task automatic test_single_class();
        clear_classes();
        cls[3] = 50'd255;
        check_query("single_class", 50'd255);
        n_cmp++;
        if (result_class !== 5'd3 || result_score !== 6'd8) begin
            n_fail++;
            $display("FAIL single_class const: cls=%0d sc=%0d want 3 8",
                     result_class, result_score);
        end
    endtask

    task automatic test_tie();
        clear_classes();
        cls[2] = 50'hF0;
        cls[5] = 50'hF0;
        check_query("tie", 50'hFF);
        n_cmp++;
        if (result_class !== 5'd2 || result_score !== 6'd4) begin
            n_fail++;
            $display("FAIL tie const: cls=%0d sc=%0d want 2 4", result_class, result_score);
        end
    endtask

    task automatic test_all_zero();
        clear_classes();
        check_query("all_zero", 50'h3_FFFF_FFFF_FFFF);
    endtask

    task automatic test_max_score();
        clear_classes();
        cls[0] = 50'h1;
        cls[25] = ONES;
        check_query("max_score", ONES);
        n_cmp++;
        if (result_class !== 5'd25 || result_score !== 6'd50) begin
            n_fail++;
            $display("FAIL max_score const: cls=%0d sc=%0d want 25 50",
                     result_class, result_score);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                cls[k] = rand_hv() & rand_hv();
            end
            check_query($sformatf("random%0d", t), rand_hv());
        end
    endtask

    task automatic test_back_to_back();
        logic [HV_WIDTH-1:0] q;
        int pulses[$];
        int m_cls, m_score, bad_res, idle_wait;
        for (int k = 0; k < NUM_CLASSES; k++) cls[k] = rand_hv() & rand_hv();
        q = rand_hv();
        model(q, m_cls, m_score);
        bad_res = 0;
        @(negedge clk);
        query_hv = q;
        query_ready = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 10) query_hv = ~q;
            if (c == 20) query_hv = q;
            if (result_valid === 1'b1) begin
                pulses.push_back(c);
                if (result_class !== CLASS_W'(m_cls) ||
                    result_score !== SCORE_W'(m_score)) bad_res++;
            end
        end
        query_ready = 1'b0;
        n_cmp++;
        if (pulses.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b count: %0d pulses want 3", pulses.size());
        end else begin
            n_cmp++;
            if (pulses[0] !== 26 || pulses[1] !== 54 || pulses[2] !== 82) begin
                n_fail++;
                $display("FAIL b2b spacing: at %0d %0d %0d want 26 54 82",
                         pulses[0], pulses[1], pulses[2]);
            end
        end
        n_cmp++;
        if (bad_res !== 0) begin
            n_fail++;
            $display("FAIL b2b result: %0d wrong results want cls=%0d score=%0d",
                     bad_res, m_cls, m_score);
        end
        idle_wait = 0;
        while (accept_en !== 1'b1 && idle_wait < 40) begin
            @(negedge clk);
            idle_wait++;
        end
        n_cmp++;
        if (accept_en !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b drain: accept_en=%b want 1", accept_en);
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        for (int k = 0; k < NUM_CLASSES; k++) cls[k] = rand_hv();
        @(negedge clk);
        query_hv = ONES;
        query_ready = 1'b1;
        @(posedge clk);
        #1 query_ready = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (state !== 2'd0 || accept_en !== 1'b1 || busy !== 1'b0 ||
            result_class !== '0 || result_score !== '0) begin
            n_fail++;
            $display("FAIL mid_reset outputs: st=%0d acc=%b busy=%b cls=%0d sc=%0d want 0/1/0/0/0",
                     state, accept_en, busy, result_class, result_score);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset pulse: %0d pulses want 0", seen);
        end
        check_query("after_reset", rand_hv());
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_single_class();
        test_tie();
        test_all_zero();
        test_random();
        test_back_to_back();
        test_max_score();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
